// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared encodings for the parallel-in/serial-out slice
package serdes_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

  localparam logic ORDER_LSB = 1'b0;
  localparam logic ORDER_MSB = 1'b1;

endpackage

// File: rtl/bit_down_counter.sv
// rtl/bit_down_counter.sv - loadable down counter flagging the final count
module bit_down_counter
  import serdes_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             is_one
);

  logic [CNT_W-1:0] count;

  // a load on the final decrement wins so back-to-back frames restart cleanly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - CNT_W'(1);
    end
  end

  assign is_one = (count == CNT_W'(1));

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out shift engine with load handshake
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             msb_first,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  ser_state_e       state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic             dir;
  logic             cnt_is_one;
  logic             step;
  logic             load_fire;

  assign step       = (state == ST_SHIFT) & shift_en;
  assign load_ready = (state == ST_IDLE) | (step & cnt_is_one);
  assign load_fire  = load_valid & load_ready;
  assign busy       = (state == ST_SHIFT);

  bit_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (load_fire),
    .load_val (CNT_W'(WIDTH)),
    .dec      (step),
    .is_one   (cnt_is_one)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (load_fire) state_nxt = ST_SHIFT;
      ST_SHIFT: if (step && cnt_is_one && !load_fire) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // the last bit of the old word leaves on the same edge the new word is captured
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg     <= '0;
      dir       <= ORDER_LSB;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      ser_valid <= step;
      ser_last  <= step & cnt_is_one;
      done      <= step & cnt_is_one;
      if (step) begin
        ser_out <= (dir == ORDER_MSB) ? shreg[WIDTH-1] : shreg[0];
      end
      if (load_fire) begin
        shreg <= load_data;
        dir   <= msb_first;
      end else if (step) begin
        shreg <= (dir == ORDER_MSB) ? (shreg << 1) : (shreg >> 1);
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for piso_serializer at WIDTH 8, 1 and 32
module tb_piso_serializer;
  import serdes_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        lv8, lr8, ms8, se8, so8, sv8, sl8, bz8, dn8;
  logic [7:0]  ld8;
  logic        lv1, lr1, ms1, se1, so1, sv1, sl1, bz1, dn1;
  logic [0:0]  ld1;
  logic        lv32, lr32, ms32, se32, so32, sv32, sl32, bz32, dn32;
  logic [31:0] ld32;

  piso_serializer #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .load_valid(lv8), .load_ready(lr8), .load_data(ld8),
    .msb_first(ms8), .shift_en(se8), .ser_out(so8), .ser_valid(sv8), .ser_last(sl8),
    .busy(bz8), .done(dn8));

  piso_serializer #(.WIDTH(1)) u1 (
    .clk(clk), .reset(reset), .load_valid(lv1), .load_ready(lr1), .load_data(ld1),
    .msb_first(ms1), .shift_en(se1), .ser_out(so1), .ser_valid(sv1), .ser_last(sl1),
    .busy(bz1), .done(dn1));

  piso_serializer #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .load_valid(lv32), .load_ready(lr32), .load_data(ld32),
    .msb_first(ms32), .shift_en(se32), .ser_out(so32), .ser_valid(sv32), .ser_last(sl32),
    .busy(bz32), .done(dn32));

  typedef struct packed {
    logic [1:0] inst;
    logic       b;
    logic       last;
  } sb_t;

  sb_t sbq[$];
  int  vcnt[3];
  int  dcnt[3];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input int k, input logic [63:0] d, input logic msb, input int w);
    for (int i = 0; i < w; i++) begin
      sb_t e;
      e.inst = 2'(k);
      e.b    = msb ? d[w-1-i] : d[i];
      e.last = (i == w - 1);
      sbq.push_back(e);
    end
  endtask

  task automatic mon(input int k, input logic v, input logic b, input logic l, input logic d);
    sb_t e;
    if (v) begin
      vcnt[k]++;
      if (sbq.size() == 0) begin
        check_val("unexpected_bit", 1, 0);
      end else begin
        e = sbq.pop_front();
        check_val("sb_inst", 64'(k), 64'(e.inst));
        check_val("ser_out", b, e.b);
        check_val("ser_last", l, e.last);
        check_val("done", d, e.last);
      end
    end else begin
      check_val("flags_no_valid", {l, d}, 0);
    end
    if (d) dcnt[k]++;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      sbq.delete();
    end else begin
      mon(0, sv8, so8, sl8, dn8);
      mon(1, sv1, so1, sl1, dn1);
      mon(2, sv32, so32, sl32, dn32);
      if (lv8 && lr8)   push_word(0, 64'(ld8), ms8, 8);
      if (lv1 && lr1)   push_word(1, 64'(ld1), ms1, 1);
      if (lv32 && lr32) push_word(2, 64'(ld32), ms32, 32);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // stall_a/stall_b name the enabled-edge indices held low; 0 means no stall
  task automatic run8(input logic [7:0] d, input logic msb, input int stall_a, input int stall_b,
                      input string tag);
    int v0, d0, n;
    v0 = vcnt[0];
    d0 = dcnt[0];
    n  = (stall_a > 0) ? 10 : 8;
    lv8 = 1'b1; ld8 = d; ms8 = msb; se8 = 1'b1;
    cyc();
    lv8 = 1'b0;
    check_val({tag, "_busy_load"}, bz8, 1);
    for (int i = 1; i <= n; i++) begin
      if (i == 3) ms8 = ~msb;
      se8 = !(i == stall_a || i == stall_b);
      cyc();
      check_val({tag, "_valid"}, sv8, se8);
      check_val({tag, "_busy"}, bz8, i != n);
    end
    se8 = 1'b1;
    cyc();
    check_val({tag, "_nvalid"}, 64'(vcnt[0] - v0), 8);
    check_val({tag, "_ndone"}, 64'(dcnt[0] - d0), 1);
    check_val({tag, "_drain"}, 64'(sbq.size()), 0);
  endtask

  task automatic b2b8(input logic [7:0] d1, input logic [7:0] d2, input int start, input string tag);
    int v0, d0;
    v0 = vcnt[0];
    d0 = dcnt[0];
    lv8 = 1'b1; ld8 = d1; ms8 = ORDER_MSB; se8 = 1'b1;
    cyc();
    lv8 = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (i == start) begin
        lv8 = 1'b1;
        ld8 = d2;
      end
      if (i <= 8) check_val({tag, "_ready"}, lr8, i == 8);
      cyc();
      if (i == 8) lv8 = 1'b0;
      check_val({tag, "_valid"}, sv8, 1);
    end
    cyc();
    check_val({tag, "_busy_end"}, bz8, 0);
    check_val({tag, "_nvalid"}, 64'(vcnt[0] - v0), 16);
    check_val({tag, "_ndone"}, 64'(dcnt[0] - d0), 2);
    check_val({tag, "_drain"}, 64'(sbq.size()), 0);
  endtask

  initial begin
    int d0, v0;
    reset = 1'b1;
    lv8 = 0; ld8 = '0; ms8 = 0; se8 = 1;
    lv1 = 0; ld1 = '0; ms1 = 0; se1 = 1;
    lv32 = 0; ld32 = '0; ms32 = 0; se32 = 1;
    for (int k = 0; k < 3; k++) begin
      vcnt[k] = 0;
      dcnt[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ser_out", so8, 0);
    check_val("rst_valid", sv8, 0);
    check_val("rst_last", sl8, 0);
    check_val("rst_done", dn8, 0);
    check_val("rst_busy", bz8, 0);
    check_val("rst_ready", lr8, 1);
    reset = 1'b0;
    cyc();

    run8(8'hC1, ORDER_MSB, 0, 0, "msb");
    run8(8'hC1, ORDER_LSB, 0, 0, "lsb");
    run8(8'hC1, ORDER_MSB, 3, 4, "stall");
    b2b8(8'hC1, 8'h3C, 1, "b2b");
    b2b8(8'hC1, 8'hFF, 3, "late");

    // abort a frame after three bits
    lv8 = 1'b1; ld8 = 8'hC1; ms8 = ORDER_MSB; se8 = 1'b1;
    cyc();
    lv8 = 1'b0;
    repeat (3) cyc();
    d0 = dcnt[0];
    #2 reset = 1'b1;
    #1;
    check_val("arst_ser_out", so8, 0);
    check_val("arst_valid", sv8, 0);
    check_val("arst_last", sl8, 0);
    check_val("arst_done", dn8, 0);
    check_val("arst_busy", bz8, 0);
    check_val("arst_ready", lr8, 1);
    cyc();
    reset = 1'b0;
    cyc();
    check_val("arst_nodone", 64'(dcnt[0] - d0), 0);
    run8(8'h81, ORDER_MSB, 0, 0, "reload");

    // WIDTH=1: single-bit frames, then a held load accepted on the last-bit cycle
    d0 = dcnt[1];
    lv1 = 1'b1; ld1 = 1'b1; ms1 = ORDER_MSB;
    cyc();
    check_val("w1_busy", bz1, 1);
    check_val("w1_ready_last", lr1, 1);
    ld1 = 1'b0; ms1 = ORDER_LSB;
    cyc();
    lv1 = 1'b0;
    check_val("w1_valid_a", sv1, 1);
    check_val("w1_last_a", sl1, 1);
    check_val("w1_busy_b2b", bz1, 1);
    cyc();
    check_val("w1_valid_b", sv1, 1);
    check_val("w1_busy_end", bz1, 0);
    cyc();
    check_val("w1_ndone", 64'(dcnt[1] - d0), 2);
    check_val("w1_drain", 64'(sbq.size()), 0);

    // WIDTH=32 MSB-first
    v0 = vcnt[2];
    d0 = dcnt[2];
    lv32 = 1'b1; ld32 = 32'h8000_0001; ms32 = ORDER_MSB;
    cyc();
    lv32 = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      cyc();
      check_val("w32_valid", sv32, 1);
      check_val("w32_busy", bz32, i != 32);
    end
    cyc();
    check_val("w32_nvalid", 64'(vcnt[2] - v0), 32);
    check_val("w32_ndone", 64'(dcnt[2] - d0), 1);
    check_val("w32_drain", 64'(sbq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parametrised parallel-in/serial-out shift engine. It accepts a WIDTH-bit word through a valid/ready load handshake and emits it one bit per enabled cycle, MSB-first or LSB-first. It provides per-bit valid, last-bit and frame-done flags. It supports stalls and back-to-back frames with no bubble, and is the serial transmit front-end for datapath words.

Parameters:
WIDTH, 32, word width in bits; legal range 1..64.
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
load_valid  input  1  load_data is valid this cycle.
load_ready  output  1  block accepts a word this cycle.
load_data  input  WIDTH  parallel word to serialise.
msb_first  input  1  bit order: 1 = MSB first, 0 = LSB first; sampled only at load.
shift_en  input  1  advance one bit this cycle; 0 = stall.
ser_out  output  1  serial data bit, registered.
ser_valid  output  1  ser_out carries a new bit this cycle.
ser_last  output  1  current bit is the final bit of the frame.
busy  output  1  a frame is in progress.
done  output  1  one-cycle pulse, coincident with ser_last.

Behaviour:
- Reset (async, dominates everything):
  - state=IDLE, shreg=0, cnt=0, dir=0.
  - ser_out=0, ser_valid=0, ser_last=0, done=0, busy=0; load_ready=1 after reset.
- States: IDLE, SHIFT. busy = (state==SHIFT).
- load_ready (combinational) = (state==IDLE) | (state==SHIFT & cnt==1 & shift_en).
- Load fires when load_valid & load_ready at a rising edge:
  - shreg<=load_data, dir<=msb_first, cnt<=WIDTH, state<=SHIFT.
  - load_valid without load_ready is ignored; the sender holds data until accepted.
- SHIFT with shift_en=1, each edge:
  - ser_out <= dir ? shreg[WIDTH-1] : shreg[0].
  - shreg shifts toward the emitted end, zero-filled (left if dir=1, right if dir=0).
  - cnt<=cnt-1, ser_valid<=1, ser_last<=(cnt==1), done<=(cnt==1).
- SHIFT with shift_en=0: shreg, cnt, state and ser_out hold; ser_valid, ser_last and done are 0.
- End of frame: on the edge where cnt==1 & shift_en, the next state is IDLE unless a load fires on the same edge. If a load fires, the new word is captured, cnt=WIDTH and state stays SHIFT. The final bit of the old frame and its done pulse are still emitted.
- IDLE: ser_valid, ser_last and done are 0; ser_out holds its last value.
- Latency:
  - First bit is visible after the first enabled edge following the load edge.
  - An unstalled frame occupies exactly WIDTH consecutive ser_valid cycles.
- WIDTH=1: each frame is one bit, with ser_last and done set on that bit.
- Reset mid-frame aborts the frame: no done pulse, and the partial word is discarded.

Decomposition:
- Package serdes_pkg holds:
  - State encoding: ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - Order constants: ORDER_LSB=1'b0, ORDER_MSB=1'b1.
- Sub-module bit_down_counter (CNT_W) provides load, decrement-enable, and an is_one flag.
- The shift register and FSM stay in the top module.

Test Plan:
- WIDTH=8, load 0xC1 with msb_first=1, shift_en=1 held high -> ser_out 1,1,0,0,0,0,0,1 on 8 consecutive ser_valid cycles; ser_last and done on the 8th; busy falls the following cycle.
- Load 0xC1 with msb_first=0 -> ser_out 1,0,0,0,0,0,1,1; msb_first toggled mid-frame has no effect.
- 0xC1 MSB-first, shift_en low for cycles 3-4 of the frame -> ser_valid low for exactly those 2 cycles; bit sequence unchanged; frame spans 10 cycles; exactly one done.
- Back-to-back: 0xC1 then 0x3C (MSB-first), second load_valid held during the frame -> load_ready high only on the last-bit cycle; 16 contiguous valid bits 11000001 00111100; two done pulses.
- load_valid with 0xFF during cycle 3 of a frame -> not accepted; current frame bits intact; word accepted on the last-bit cycle.
- Reset asserted asynchronously after 3 bits -> all outputs 0 immediately, load_ready=1, no done; next load of 0x81 serialises correctly. Repeat test 1 with WIDTH=1 and WIDTH=32 (0x80000001).
